// File: rtl/rv32i_rf_wb_arbiter_if.sv
// Bundle for the register-file writeback arbiter: requester handshakes, issue-side
// destination claims, source busy queries and the registered register-file write port.
interface rv32i_rf_wb_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 5
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*IDX_W-1:0]  req_rd;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  logic                      claim_valid;
  logic [IDX_W-1:0]          claim_rd;
  logic                      claim_ready;

  logic [IDX_W-1:0]          chk_rs1;
  logic [IDX_W-1:0]          chk_rs2;
  logic                      busy_rs1;
  logic                      busy_rs2;

  logic                      rf_wen;
  logic [IDX_W-1:0]          rf_rd;
  logic [DATA_W-1:0]         rf_w_data;

  modport master (
    output req_valid, req_rd, req_data, claim_valid, claim_rd, chk_rs1, chk_rs2,
    input  req_ready, claim_ready, busy_rs1, busy_rs2, rf_wen, rf_rd, rf_w_data
  );

  modport slave (
    input  req_valid, req_rd, req_data, claim_valid, claim_rd, chk_rs1, chk_rs2,
    output req_ready, claim_ready, busy_rs1, busy_rs2, rf_wen, rf_rd, rf_w_data
  );
endinterface

// File: rtl/rv32i_rf_wb_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between writeback
// sources, with a pending-write scoreboard used by issue for hazard stalls.
module rv32i_rf_wb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 5
) (
  input logic                  i_clk,
  input logic                  i_rst,
  rv32i_rf_wb_arbiter_if.slave bus
);
  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NUM_REGS = 1 << IDX_W;

  logic [PTR_W-1:0]    r_ptr;
  logic [NUM_REGS-1:0] r_pending;
  logic                r_rf_wen;
  logic [IDX_W-1:0]    r_rf_rd;
  logic [DATA_W-1:0]   r_rf_w_data;

  logic                w_hs;
  logic [PTR_W-1:0]    w_gnt;
  logic [PTR_W-1:0]    w_cand;
  logic [NUM_REQ-1:0]  w_ready;
  logic [IDX_W-1:0]    w_gnt_rd;
  logic [DATA_W-1:0]   w_gnt_data;
  logic                w_claim_ok;
  logic [NUM_REGS-1:0] w_pending_nxt;

  // Walk the requesters starting just after the last winner; a reset cycle grants nothing.
  always_comb begin
    w_hs   = 1'b0;
    w_gnt  = '0;
    w_cand = r_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = (w_cand == PTR_W'(NUM_REQ - 1)) ? '0 : w_cand + 1'b1;
      if (!w_hs && !i_rst && bus.req_valid[w_cand]) begin
        w_hs  = 1'b1;
        w_gnt = w_cand;
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_hs) w_ready[w_gnt] = 1'b1;
  end

  assign w_gnt_rd   = bus.req_rd[int'(w_gnt) * IDX_W +: IDX_W];
  assign w_gnt_data = bus.req_data[int'(w_gnt) * DATA_W +: DATA_W];

  assign w_claim_ok = bus.claim_valid & ~i_rst & (bus.claim_rd != '0) & ~r_pending[bus.claim_rd];

  // A claim is applied after the completion so a same-cycle re-claim stays outstanding.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_hs && (w_gnt_rd != '0)) w_pending_nxt[w_gnt_rd] = 1'b0;
    if (w_claim_ok) w_pending_nxt[bus.claim_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr       <= PTR_W'(NUM_REQ - 1);
      r_pending   <= '0;
      r_rf_wen    <= 1'b0;
      r_rf_rd     <= '0;
      r_rf_w_data <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_hs) begin
        r_ptr       <= w_gnt;
        r_rf_rd     <= w_gnt_rd;
        r_rf_w_data <= w_gnt_data;
        r_rf_wen    <= (w_gnt_rd != '0);
      end else begin
        r_rf_wen <= 1'b0;
      end
    end
  end

  // The output-stage term covers the cycle before the register file holds the new value.
  assign bus.busy_rs1 = (bus.chk_rs1 != '0) &
                        (r_pending[bus.chk_rs1] | (r_rf_wen & (r_rf_rd == bus.chk_rs1)));
  assign bus.busy_rs2 = (bus.chk_rs2 != '0) &
                        (r_pending[bus.chk_rs2] | (r_rf_wen & (r_rf_rd == bus.chk_rs2)));

  assign bus.req_ready   = w_ready;
  assign bus.claim_ready = w_claim_ok;
  assign bus.rf_wen      = r_rf_wen;
  assign bus.rf_rd       = r_rf_rd;
  assign bus.rf_w_data   = r_rf_w_data;
endmodule
